antirebote_ar: RTL and testbench
================================

Name: antirebote_ar

Overview:
- Single-channel synchronizing debouncer for mechanical buttons and noisy sensor inputs.
- Replaces the per-button and per-sensor filter instances in the input front-end.
- Raw asynchronous input → synchronizer → stability counter → filtered level.
- Also produces edge pulses and an optional falling-edge toggle that the control FSM consumes.

Parameters:
- N, 5, consecutive clock cycles the synchronized input must differ from sig_out before sig_out follows it. Legal range is N ≥ 1. Buttons use 5 (sim) / 50000+ (HW); sensors use 10.
- SYNC_STAGES, 2, number of synchronizer flip-flops. Legal range 1..3.
- CNT_W, derived: the smallest width that can hold N. Not overridable.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- sig_in  input  1  raw asynchronous button/sensor level.
- sig_out  output  1  debounced level.
- rise_pulse  output  1  one-cycle high when sig_out has just gone 0→1.
- fall_pulse  output  1  one-cycle high when sig_out has just gone 1→0.
- toggle_out  output  1  flips on every fall_pulse (see Optional Feature).

Behaviour:
- All outputs and internal state are registered, with no combinational path from sig_in.
- Reset, sampled on posedge while reset=1:
  - synchronizer flops, counter, sig_out, rise_pulse, fall_pulse and toggle_out all go to 0.
  - Reset dominates every other event on the same edge.
  - Reset mid-count discards the partial count.
- Synchronizer: sig_in shifts through SYNC_STAGES flops. The last flop is s.
- Counter cnt (CNT_W bits), evaluated each posedge outside reset:
  - if s == sig_out: cnt <= 0.
  - else if cnt == N-1: sig_out <= s and cnt <= 0.
  - else: cnt <= cnt+1.
- Latency: sig_in is sampled at edge e and held stable. sig_out changes at edge e + (SYNC_STAGES-1) + N. With defaults this is edge e+6.
- Glitch rejection: if s returns to equal sig_out before N consecutive disagreeing edges, cnt clears and sig_out is unchanged. A pulse of N-1 cycles at s never propagates.
- Counter never exceeds N-1, so no wrap-around can occur.
- N=1: sig_out follows s one edge later, with no filtering.
- Edge pulses are registered on the same edge as the sig_out update:
  - rise_pulse=1 for exactly the one cycle in which sig_out first reads 1.
  - fall_pulse=1 for exactly the one cycle in which sig_out first reads 0.
  - Both are 0 otherwise.
  - They are never high together.
  - Back-to-back pulses are impossible for N ≥ 1, since at least N cycles separate transitions.
- toggle_out: on the edge that sets fall_pulse, toggle_out <= ~toggle_out. This gives a press-to-toggle switch on button release.

Optional Feature:
- Macro ANTIREBOTE_TOGGLE_EN.
- Defined: toggle_out behaves as above (one toggle register).
- Undefined: no toggle register is built, and toggle_out is tied to 0.
- sig_out, rise_pulse and fall_pulse are identical in both builds.

Test Plan:
- Reset, N=5, SYNC_STAGES=2: hold reset 3 cycles with sig_in=1 → all outputs 0 throughout reset; after release, sig_out rises exactly 6 edges after the first sampling edge.
- Press: sig_in 0→1 held 20 cycles → sig_out=1 at edge e+6; rise_pulse high that single cycle; fall_pulse stays 0.
- Glitch: sig_in high for 4 cycles, then low → sig_out stays 0, no pulses. Repeat with 5 cycles high → sig_out rises 6 edges after the first sampling edge, then falls 6 edges after the first low sampling edge.
- Bounce: sig_in alternates every 2 cycles for 30 cycles, then settles at 1 → sig_out changes exactly once, 6 edges after the final settle.
- Toggle (ANTIREBOTE_TOGGLE_EN defined): three full press/release cycles → fall_pulse fires 3 times; toggle_out goes 1,0,1. Rebuild without the macro → toggle_out constant 0.
- Reset mid-count with N=10: sig_in=1 for 7 cycles, assert reset 1 cycle, then release with sig_in still 1 → sig_out stays 0 until 11 edges after release.

Source files
------------

// File: rtl/antirebote_ar.sv
// antirebote_ar: single-channel synchronizing debouncer.
//   sig_in -> SYNC_STAGES-flop synchronizer -> stability counter -> sig_out,
//   plus registered rise/fall pulses on every sig_out transition.
// Optional build macro: ANTIREBOTE_TOGGLE_EN
//   defined   : toggle_out flips on every fall_pulse (press-to-toggle on release)
//   undefined : no toggle register, toggle_out tied to 0
module antirebote_ar #(
  parameter int N           = 5,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic sig_in,
  output logic sig_out,
  output logic rise_pulse,
  output logic fall_pulse,
  output logic toggle_out
);

  // Smallest width able to hold N; the counter itself only ever reaches N-1.
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [SYNC_STAGES-1:0] sync_next_s;
  logic                   sync_s;
  logic [CNT_W-1:0]       cnt_r;
  logic [CNT_W-1:0]       cnt_next_s;
  logic                   sig_out_r;
  logic                   sig_out_next_s;
  logic                   rise_r;
  logic                   rise_next_s;
  logic                   fall_r;
  logic                   fall_next_s;

  // Last synchronizer stage is the only point where the async input is used.
  assign sync_s = sync_r[SYNC_STAGES-1];

  // Shift network for the synchronizer chain (works for a single stage too).
  always_comb begin
    sync_next_s    = sync_r;
    sync_next_s[0] = sig_in;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_next_s[i] = sync_r[i-1];
    end
  end

  // Synchronizer flops; reset clears them so stale pre-reset samples are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_r <= {SYNC_STAGES{1'b0}};
    end else begin
      sync_r <= sync_next_s;
    end
  end

  // Stability counter: count consecutive disagreeing cycles, commit at N.
  always_comb begin
    cnt_next_s     = cnt_r;
    sig_out_next_s = sig_out_r;
    rise_next_s    = 1'b0;
    fall_next_s    = 1'b0;
    if (sync_s == sig_out_r) begin
      // Agreement (or a glitch that returned) discards any partial count.
      cnt_next_s = CNT_ZERO;
    end else if (cnt_r == CNT_LAST) begin
      // N-th consecutive disagreement: follow the input and flag the edge.
      cnt_next_s     = CNT_ZERO;
      sig_out_next_s = sync_s;
      rise_next_s    = sync_s;
      fall_next_s    = ~sync_s;
    end else begin
      cnt_next_s = cnt_r + CNT_ONE;
    end
  end

  // Counter, filtered level and edge pulses share one register stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_r     <= CNT_ZERO;
      sig_out_r <= 1'b0;
      rise_r    <= 1'b0;
      fall_r    <= 1'b0;
    end else begin
      cnt_r     <= cnt_next_s;
      sig_out_r <= sig_out_next_s;
      rise_r    <= rise_next_s;
      fall_r    <= fall_next_s;
    end
  end

  assign sig_out    = sig_out_r;
  assign rise_pulse = rise_r;
  assign fall_pulse = fall_r;

`ifdef ANTIREBOTE_TOGGLE_EN
  logic toggle_r;

  // Toggle flips on the same edge that raises fall_pulse (button release).
  always_ff @(posedge clk) begin
    if (reset) begin
      toggle_r <= 1'b0;
    end else if (fall_next_s) begin
      toggle_r <= ~toggle_r;
    end else begin
      toggle_r <= toggle_r;
    end
  end

  assign toggle_out = toggle_r;
`else
  assign toggle_out = 1'b0;
`endif

endmodule

// File: tb/tb_antirebote_ar.sv
// Self-checking bench for antirebote_ar: two instances (N=5 and N=10, two
// synchronizer stages) fed by the same input, a window-based reference model
// compared every cycle, plus literal timing checks from the directed scenarios.
module tb_antirebote_ar;

  localparam int SYNC = 2;
  localparam int N_A  = 5;
  localparam int N_B  = 10;
`ifdef ANTIREBOTE_TOGGLE_EN
  localparam bit TOG_EN = 1'b1;
`else
  localparam bit TOG_EN = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic sig_in = 1'b0;
  logic rst_a  = 1'b1;
  logic rst_b  = 1'b1;
  logic out_a, rise_a, fall_a, tog_a;
  logic out_b, rise_b, fall_b, tog_b;

  antirebote_ar #(.N(N_A), .SYNC_STAGES(SYNC)) dut_a (
    .clk(clk), .reset(rst_a), .sig_in(sig_in),
    .sig_out(out_a), .rise_pulse(rise_a), .fall_pulse(fall_a), .toggle_out(tog_a)
  );

  antirebote_ar #(.N(N_B), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .reset(rst_b), .sig_in(sig_in),
    .sig_out(out_b), .rise_pulse(rise_b), .fall_pulse(fall_b), .toggle_out(tog_b)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int rise_cnt_a = 0, fall_cnt_a = 0;
  int rise_cnt_b = 0, fall_cnt_b = 0;

  task automatic check(input string name, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0b expected %0b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the filtered level flips when the last N synchronized
  // samples all disagree with it; the synchronized sample is sig_in delayed.
  int   n_of [2] = '{N_A, N_B};
  logic pipe [2][SYNC];
  logic hist [2][16];
  logic m_out [2], m_rise [2], m_fall [2], m_tog [2];

  initial begin
    logic r, s;
    bit   all_diff;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < SYNC; i++) pipe[k][i] = 1'b0;
      for (int j = 0; j < 16; j++) hist[k][j] = 1'b0;
      m_out[k] = 1'b0; m_rise[k] = 1'b0; m_fall[k] = 1'b0; m_tog[k] = 1'b0;
    end
    forever begin
      @(posedge clk);
      for (int k = 0; k < 2; k++) begin
        r = (k == 0) ? rst_a : rst_b;
        if (r) begin
          for (int i = 0; i < SYNC; i++) pipe[k][i] = 1'b0;
          for (int j = 0; j < 16; j++) hist[k][j] = 1'b0;
          m_out[k] = 1'b0; m_rise[k] = 1'b0; m_fall[k] = 1'b0; m_tog[k] = 1'b0;
        end else begin
          s = pipe[k][SYNC-1];
          for (int i = SYNC - 1; i > 0; i--) pipe[k][i] = pipe[k][i-1];
          pipe[k][0] = sig_in;
          for (int j = 15; j > 0; j--) hist[k][j] = hist[k][j-1];
          hist[k][0] = s;
          all_diff = 1'b1;
          for (int j = 0; j < n_of[k]; j++) if (hist[k][j] == m_out[k]) all_diff = 1'b0;
          m_rise[k] = 1'b0;
          m_fall[k] = 1'b0;
          if (all_diff) begin
            m_out[k]  = s;
            m_rise[k] = s;
            m_fall[k] = ~s;
            if (!s) m_tog[k] = ~m_tog[k];
          end
        end
      end
    end
  end

  // Every-cycle comparison against the model, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      check("a_sig_out", out_a, m_out[0]);
      check("a_rise", rise_a, m_rise[0]);
      check("a_fall", fall_a, m_fall[0]);
      check("a_toggle", tog_a, m_tog[0] & TOG_EN);
      check("b_sig_out", out_b, m_out[1]);
      check("b_rise", rise_b, m_rise[1]);
      check("b_fall", fall_b, m_fall[1]);
      check("b_toggle", tog_b, m_tog[1] & TOG_EN);
      if (rise_a === 1'b1 && fall_a === 1'b1) check("a_pulses_exclusive", 1'b1, 1'b0);
      if (rise_a === 1'b1) rise_cnt_a++;
      if (fall_a === 1'b1) fall_cnt_a++;
      if (rise_b === 1'b1) rise_cnt_b++;
      if (fall_b === 1'b1) fall_cnt_b++;
    end
  end

  // Advance n falling edges, then settle 1 time unit past them.
  task automatic step(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    int r0, f0;
    // Reset held 3 cycles with sig_in high: everything stays 0.
    sig_in = 1'b1; rst_a = 1'b1; rst_b = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check("rst_sig_out", out_a, 1'b0);
      check("rst_rise", rise_a, 1'b0);
      check("rst_fall", fall_a, 1'b0);
      check("rst_toggle", tog_a, 1'b0);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    // First sampling edge e follows; sig_out must rise at e+6.
    step(6);
    check("post_rst_e5_low", out_a, 1'b0);
    step(1);
    check("post_rst_e6_high", out_a, 1'b1);
    check("post_rst_e6_rise", rise_a, 1'b1);
    step(1);
    check("post_rst_rise_one_cycle", rise_a, 1'b0);

    // Press held for 20 cycles in total: no fall pulse.
    step(12);
    check("press_held", out_a, 1'b1);
    check_int("press_no_fall", fall_cnt_a, 0);
    sig_in = 1'b0;
    step(7);
    check("release_low", out_a, 1'b0);
    check("release_fall", fall_a, 1'b1);
    step(10);

    // Glitch of 4 cycles is rejected.
    r0 = rise_cnt_a;
    sig_in = 1'b1; step(4);
    sig_in = 1'b0; step(12);
    check("glitch4_low", out_a, 1'b0);
    check_int("glitch4_no_rise", rise_cnt_a, r0);

    // 5-cycle pulse: rises at e+6, falls 6 edges after first low sample (e+11).
    sig_in = 1'b1; step(5);
    sig_in = 1'b0; step(2);
    check("pulse5_rise_level", out_a, 1'b1);
    check("pulse5_rise_pulse", rise_a, 1'b1);
    step(4);
    check("pulse5_still_high", out_a, 1'b1);
    step(1);
    check("pulse5_fall_level", out_a, 1'b0);
    check("pulse5_fall_pulse", fall_a, 1'b1);
    step(10);

    // Bounce: 2-cycle alternation for 30 cycles, then settle high.
    r0 = rise_cnt_a; f0 = fall_cnt_a;
    for (int seg = 0; seg < 15; seg++) begin
      sig_in = (seg % 2 == 1) ? 1'b1 : 1'b0;
      step(2);
    end
    sig_in = 1'b1;
    step(6);
    check("bounce_e5_low", out_a, 1'b0);
    check_int("bounce_no_early_rise", rise_cnt_a, r0);
    step(1);
    check("bounce_e6_high", out_a, 1'b1);
    step(5);
    check_int("bounce_one_rise", rise_cnt_a, r0 + 1);
    check_int("bounce_no_fall", fall_cnt_a, f0);

    // Toggle: three press/release cycles after a fresh reset.
    sig_in = 1'b0; rst_a = 1'b1; rst_b = 1'b1;
    step(2);
    rst_a = 1'b0; rst_b = 1'b0;
    step(2);
    f0 = fall_cnt_a;
    for (int p = 0; p < 3; p++) begin
      sig_in = 1'b1; step(10);
      sig_in = 1'b0; step(10);
      check("toggle_after_release", tog_a, TOG_EN & (p % 2 == 0));
    end
    check_int("toggle_three_falls", fall_cnt_a - f0, 3);

    // Reset mid-count on the N=10 instance discards the partial count.
    step(15);
    check("midrst_start_low", out_b, 1'b0);
    sig_in = 1'b1; step(7);
    rst_b = 1'b1; step(1);
    check("midrst_in_reset", out_b, 1'b0);
    rst_b = 1'b0;
    step(11);
    check("midrst_r10_low", out_b, 1'b0);
    step(1);
    check("midrst_r11_high", out_b, 1'b1);
    check("midrst_r11_rise", rise_b, 1'b1);
    step(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
